pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencing controller for the RISC-V core, replacing the fixed per-stage stall logic at core top.
- Tracks a valid bit per stage and generates per-stage stall/flush for the STAGES-deep pipeline, handling external memory wait, multi-cycle (mul/div) occupancy, load-use interlock and taken-jump flush.
- Sits beside the stage modules in the core top; the stage modules consume `valid`/`stall`/`flush`.

Parameters:
- STAGES, 5: pipeline depth, legal range 4..8. Stage 0 = IF, 1 = ID.
- EX_STAGE, 2: index of the execute stage, legal range 2..STAGES-2.
- REG_ADDR_W, 5: register address width.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  fetch enable; a new instruction enters IF each unstalled cycle while high
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_rs1_en  in  1  ID uses rs1
- id_rs2_en  in  1  ID uses rs2
- id_rd  in  REG_ADDR_W  ID destination register
- id_rd_we  in  1  ID writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_mc  in  1  ID instruction is multi-cycle (mul/div)
- ex_jump  in  1  taken branch/jal/jalr resolved in EX this cycle
- mc_done  in  1  multi-cycle unit result valid this cycle
- mem_busy  in  1  data memory not ready; freeze whole pipe
- valid  out  STAGES  per-stage valid bit (registered)
- stall  out  STAGES  per-stage hold (combinational)
- flush  out  STAGES  per-stage kill (combinational)
- load_hazard  out  1  load-use interlock active this cycle
- mc_hazard  out  1  multi-cycle wait active this cycle
- stall_cnt  out  CNT_W  cycles with any `stall` bit set, saturating
- flush_cnt  out  CNT_W  valid instructions killed by flush, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - `valid`, the metadata registers, `stall_cnt` and `flush_cnt` clear to 0.
  - `stall`, `flush`, `load_hazard` and `mc_hazard` are therefore 0.
- Metadata registers per stage 2..STAGES-1: `rd`, `rd_we`, `is_load`, `is_mc`. They are captured from the id_* inputs when ID advances into EX, and shift along with `valid`.
- Normal advance, when no stage is stalled:
  - `valid[0]` <= `run`.
  - `valid[i]` <= `valid[i-1]`.
- Condition definitions, all qualified by `valid[EX_STAGE]`:
  - MC: EX `is_mc` & !`mc_done`.
  - JMP: `ex_jump`.
  - LU: EX `is_load` & EX `rd_we` & EX `rd`!=0 & `valid[1]` & ((`id_rs1_en` & `id_rs1`==EX `rd`) | (`id_rs2_en` & `id_rs2`==EX `rd`)).
- Priority is `mem_busy` > MC > JMP > LU. Only the highest-priority active condition acts.
- `mem_busy`:
  - `stall` = all ones; no register changes except `stall_cnt`.
  - `load_hazard` and `mc_hazard` read 0.
- MC:
  - `stall[0..EX_STAGE]`=1; `valid[EX_STAGE+1]` <= 0 (bubble); later stages advance.
  - `mc_hazard`=1.
  - On the cycle `mc_done`=1, EX advances normally.
- JMP:
  - `flush[1..EX_STAGE-1]`=1 and `flush[0]`=1; there is no stall.
  - Next cycle: `valid[1..EX_STAGE]` <= 0, `valid[0]` <= `run`, and `valid[EX_STAGE+1]` <= 1 (the jump itself).
  - `flush_cnt` += popcount(`valid[0..EX_STAGE-1]`).
- LU:
  - `stall[0]` = `stall[1]` = 1; `valid[EX_STAGE]` <= 0 (bubble); stages above EX advance.
  - `load_hazard`=1. The hazard clears after one cycle for EX_STAGE=2.
- Counters:
  - `stall_cnt` += 1 when |`stall`.
  - Both counters saturate at all-ones.
- `run` low: only bubbles enter IF and the pipe drains; hazard logic continues on the remaining valid stages.
- Reset mid-operation (MC wait, flush) aborts immediately to the reset state; there is no pending state.
- An EX-stage `ex_jump` with `valid[EX_STAGE]`=0 is ignored. `mc_done` with EX not MC is ignored.

Test Plan:
- Reset, then `run`=1 for 6 cycles, no hazards -> `valid` = 00001, 00011, 00111, 01111, 11111, 11111 (bit 0 = IF); `stall`=`flush`=0; both counters 0.
- Full pipe: ID has rs1=5 with rs1_en; EX holds a load with rd=5 and rd_we -> one cycle with `load_hazard`=1 and `stall`=00011; next cycle `valid[2]`=0; `stall_cnt`=1.
- Same as previous but load rd=0 -> no stall, `load_hazard`=0.
- Full pipe, `ex_jump`=1 for one cycle -> `flush[1:0]`=11; next cycle `valid[2:1]`=00 and `valid[3]`=1; `flush_cnt`=2.
- EX holds a mul with `mc_done` low for 4 cycles, then high -> `mc_hazard`=1 for 4 cycles with `stall`=00111; `valid[3]`=0 during the wait; EX advances on the `mc_done` cycle; `stall_cnt`=4.
- `mem_busy`=1 concurrent with LU and `ex_jump` -> `stall`=11111, `flush`=0, `valid` frozen. Release `mem_busy` -> JMP acts first. Assert reset low mid-MC-wait -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller.
//
// Tracks a valid bit per pipeline stage and produces per-stage stall and flush
// for the stage modules. It handles the external data-memory wait, multi-cycle
// (mul/div) occupancy of EX, the load-use interlock between EX and ID, and the
// flush of younger stages behind a jump taken in EX.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   run               fetch enable; a new instruction enters IF each unstalled cycle
//   id_*              decode-stage register usage and instruction class
//   ex_jump           taken branch/jal/jalr resolved in EX this cycle
//   mc_done           multi-cycle unit result valid this cycle
//   mem_busy          data memory not ready; freezes the whole pipe
//   valid             per-stage valid (registered), bit 0 = IF
//   stall, flush      per-stage hold / kill (combinational)
//   load_hazard       load-use interlock active this cycle
//   mc_hazard         multi-cycle wait active this cycle
//   stall_cnt         cycles with any stall bit set (saturating)
//   flush_cnt         valid instructions killed by a flush (saturating)
module pipe_ctrl #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned EX_STAGE   = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_en,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  id_is_mc,
  input  logic                  ex_jump,
  input  logic                  mc_done,
  input  logic                  mem_busy,
  output logic [STAGES-1:0]     valid,
  output logic [STAGES-1:0]     stall,
  output logic [STAGES-1:0]     flush,
  output logic                  load_hazard,
  output logic                  mc_hazard,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Elaboration-time parameter sanity.
  if (STAGES < 4 || STAGES > 8) begin : g_bad_stages
    $error("pipe_ctrl: STAGES must be in 4..8");
  end
  if (EX_STAGE < 2 || EX_STAGE > STAGES - 2) begin : g_bad_ex
    $error("pipe_ctrl: EX_STAGE must be in 2..STAGES-2");
  end
  if (CNT_W < 4) begin : g_bad_cnt
    $error("pipe_ctrl: CNT_W must be at least 4");
  end

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-stage instruction metadata carried from ID onwards.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  is_load;
    logic                  is_mc;
  } meta_t;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] valid_up;  // value each stage takes when it advances
  logic [STAGES-1:0] adv;       // stage register loads from upstream
  logic [STAGES-1:0] kill;      // stage becomes a bubble next cycle

  meta_t meta_q  [2:STAGES-1];
  meta_t meta_up [2:STAGES-1];
  meta_t ex_meta;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W:0]   flush_sum;
  logic [3:0]       flush_pop;

  logic ex_v;
  logic rs_match;
  logic mc_c, jmp_c, lu_c;
  logic act_mc, act_jmp, act_lu;

  // ---------------------------------------------------------------------------
  // Hazard conditions, all qualified by a valid instruction in EX
  // ---------------------------------------------------------------------------
  assign ex_meta  = meta_q[EX_STAGE];
  assign ex_v     = valid_q[EX_STAGE];
  assign rs_match = (id_rs1_en && (id_rs1 == ex_meta.rd)) ||
                    (id_rs2_en && (id_rs2 == ex_meta.rd));

  assign mc_c  = ex_v & ex_meta.is_mc & ~mc_done;
  assign jmp_c = ex_v & ex_jump;
  assign lu_c  = ex_v & ex_meta.is_load & ex_meta.rd_we & (ex_meta.rd != '0) &
                 valid_q[1] & rs_match;

  // Strict priority: mem_busy > MC > JMP > LU; only the winner acts.
  assign act_mc  = ~mem_busy & mc_c;
  assign act_jmp = ~mem_busy & ~mc_c & jmp_c;
  assign act_lu  = ~mem_busy & ~mc_c & ~jmp_c & lu_c;

  assign load_hazard = act_lu;
  assign mc_hazard   = act_mc;

  // ---------------------------------------------------------------------------
  // Stall / flush decode and per-stage advance control
  // ---------------------------------------------------------------------------
  always_comb begin
    stall = '0;
    flush = '0;
    adv   = '1;
    kill  = '0;
    if (mem_busy) begin
      stall = '1;
      adv   = '0;
    end else if (act_mc) begin
      // Hold IF..EX on the multi-cycle op; the stage behind EX gets a bubble.
      for (int unsigned i = 0; i <= EX_STAGE; i++) begin
        stall[i] = 1'b1;
        adv[i]   = 1'b0;
      end
      kill[EX_STAGE+1] = 1'b1;
    end else if (act_jmp) begin
      // Kill the wrong-path instructions younger than the jump. IF is
      // refilled from run, so only stages 1..EX are forced to bubbles.
      for (int unsigned i = 0; i < EX_STAGE; i++) begin
        flush[i] = 1'b1;
      end
      for (int unsigned i = 1; i <= EX_STAGE; i++) begin
        kill[i] = 1'b1;
      end
    end else if (act_lu) begin
      // Hold IF and ID; the stage ID would have entered becomes a bubble so
      // the load moves on and the dependent instruction retries next cycle.
      stall[0] = 1'b1;
      stall[1] = 1'b1;
      adv[0]   = 1'b0;
      adv[1]   = 1'b0;
      kill[2]  = 1'b1;
    end
  end

  assign valid_up = {valid_q[STAGES-2:0], run};
  assign valid_d  = ((adv & valid_up) | (~adv & valid_q)) & ~kill;

  // Metadata shift sources: stage 2 captures from ID, later stages shift.
  always_comb begin
    meta_up[2] = '{rd: id_rd, rd_we: id_rd_we, is_load: id_is_load, is_mc: id_is_mc};
    for (int unsigned i = 3; i < STAGES; i++) begin
      meta_up[i] = meta_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters (saturating)
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_pop = '0;
    for (int unsigned i = 0; i < EX_STAGE; i++) begin
      flush_pop = flush_pop + {3'b000, valid_q[i]};
    end
  end

  assign flush_sum = {1'b0, flush_cnt_q} + {{(CNT_W-3){1'b0}}, flush_pop};

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    flush_cnt_d = flush_cnt_q;
    if (act_jmp) begin
      flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int unsigned i = 2; i < STAGES; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int unsigned i = 2; i < STAGES; i++) begin
        if (adv[i]) begin
          meta_q[i] <= meta_up[i];
        end
      end
    end
  end

  assign valid     = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with the default 5-stage, EX=2 configuration.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next rising edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_en, id_rs2_en, id_rd_we, id_is_load, id_is_mc;
  logic        ex_jump, mc_done, mem_busy;
  logic [4:0]  valid, stall, flush;
  logic        load_hazard, mc_hazard;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .STAGES    (5),
    .EX_STAGE  (2),
    .REG_ADDR_W(5),
    .CNT_W     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_en  (id_rs1_en),
    .id_rs2_en  (id_rs2_en),
    .id_rd      (id_rd),
    .id_rd_we   (id_rd_we),
    .id_is_load (id_is_load),
    .id_is_mc   (id_is_mc),
    .ex_jump    (ex_jump),
    .mc_done    (mc_done),
    .mem_busy   (mem_busy),
    .valid      (valid),
    .stall      (stall),
    .flush      (flush),
    .load_hazard(load_hazard),
    .mc_hazard  (mc_hazard),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] fill_exp [6];
  logic [4:0] mc_exp   [4];

  initial begin
    fill_exp = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
    mc_exp   = '{5'b11111, 5'b10111, 5'b00111, 5'b00111};

    reset = 1'b1; run = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rd_we = 1'b0;
    id_is_load = 1'b0; id_is_mc = 1'b0;
    ex_jump = 1'b0; mc_done = 1'b0; mem_busy = 1'b0;
    #2 reset = 1'b0;
    #10;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_lh", 32'(load_hazard), 32'h0);
    check("rst_mh", 32'(mc_hazard), 32'h0);
    check("rst_scnt", stall_cnt, 32'h0);
    check("rst_fcnt", flush_cnt, 32'h0);
    tick();
    reset = 1'b1;

    // Fill with no hazards.
    run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("fill_valid%0d", k), 32'(valid), 32'(fill_exp[k]));
      check($sformatf("fill_stall%0d", k), 32'(stall), 32'h0);
      check($sformatf("fill_flush%0d", k), 32'(flush), 32'h0);
    end
    check("fill_scnt", stall_cnt, 32'h0);
    check("fill_fcnt", flush_cnt, 32'h0);

    // Load rd=5 into EX, then ID reads x5 through rs1.
    id_is_load = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1;
    #1 check("lu_inj_stall", 32'(stall), 32'h0);
    tick();
    id_is_load = 1'b0; id_rd_we = 1'b0; id_rd = 5'd0;
    id_rs1 = 5'd5; id_rs1_en = 1'b1;
    #1;
    check("lu_hazard", 32'(load_hazard), 32'h1);
    check("lu_stall", 32'(stall), 32'h03);
    check("lu_flush", 32'(flush), 32'h0);
    check("lu_mh", 32'(mc_hazard), 32'h0);
    tick();
    id_rs1_en = 1'b0;
    #1;
    check("lu_bubble_valid", 32'(valid), 32'h1b);
    check("lu_cleared", 32'(load_hazard), 32'h0);
    check("lu_after_stall", 32'(stall), 32'h0);
    check("lu_scnt", stall_cnt, 32'h1);

    // Load to x0 never interlocks.
    id_is_load = 1'b1; id_rd = 5'd0; id_rd_we = 1'b1;
    #1 check("lu0_inj_stall", 32'(stall), 32'h0);
    tick();
    id_is_load = 1'b0; id_rd_we = 1'b0;
    id_rs1 = 5'd0; id_rs1_en = 1'b1;
    #1;
    check("lu0_valid", 32'(valid), 32'h17);
    check("lu0_hazard", 32'(load_hazard), 32'h0);
    check("lu0_stall", 32'(stall), 32'h0);
    tick();
    id_rs1_en = 1'b0;

    // Taken jump with IF and ID valid.
    ex_jump = 1'b1;
    #1;
    check("jmp_pre_valid", 32'(valid), 32'h0f);
    check("jmp_flush", 32'(flush), 32'h03);
    check("jmp_stall", 32'(stall), 32'h0);
    tick();
    // ex_jump still high but EX is now a bubble: ignored.
    #1;
    check("jmp_valid", 32'(valid), 32'h19);
    check("jmp_fcnt", flush_cnt, 32'h2);
    check("jmp_ignored_flush", 32'(flush), 32'h0);
    ex_jump = 1'b0;
    tick(); tick(); tick(); tick();
    check("refill_valid", 32'(valid), 32'h1f);

    // Multi-cycle op in EX waits four cycles, finishes on the fifth.
    id_is_mc = 1'b1;
    tick();
    id_is_mc = 1'b0; mc_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) ex_jump = 1'b1;  // MC outranks JMP
      #1;
      check($sformatf("mc_hazard%0d", k), 32'(mc_hazard), 32'h1);
      check($sformatf("mc_stall%0d", k), 32'(stall), 32'h07);
      check($sformatf("mc_valid%0d", k), 32'(valid), 32'(mc_exp[k]));
      if (k == 1) check("mc_over_jmp_flush", 32'(flush), 32'h0);
      ex_jump = 1'b0;
      tick();
    end
    mc_done = 1'b1;
    #1;
    check("mc_done_hazard", 32'(mc_hazard), 32'h0);
    check("mc_done_stall", 32'(stall), 32'h0);
    check("mc_done_valid", 32'(valid), 32'h07);
    tick();
    mc_done = 1'b0;
    #1;
    check("mc_adv_valid", 32'(valid), 32'h0f);
    // 1 earlier load-use stall + 4 MC wait cycles.
    check("mc_scnt", stall_cnt, 32'h5);

    // mem_busy alongside LU and JMP.
    id_is_load = 1'b1; id_rd = 5'd5; id_rd_we = 1'b1;
    tick();
    id_is_load = 1'b0; id_rd_we = 1'b0; id_rd = 5'd0;
    id_rs2 = 5'd5; id_rs2_en = 1'b1; ex_jump = 1'b1; mem_busy = 1'b1;
    #1;
    check("mb_stall", 32'(stall), 32'h1f);
    check("mb_flush", 32'(flush), 32'h0);
    check("mb_lh", 32'(load_hazard), 32'h0);
    check("mb_mh", 32'(mc_hazard), 32'h0);
    tick();
    check("mb_frozen_valid", 32'(valid), 32'h1f);
    check("mb_scnt", stall_cnt, 32'h6);
    mem_busy = 1'b0;
    #1;
    check("rel_flush", 32'(flush), 32'h03);
    check("rel_stall", 32'(stall), 32'h0);
    check("rel_lh", 32'(load_hazard), 32'h0);
    tick();
    ex_jump = 1'b0; id_rs2_en = 1'b0;
    #1;
    check("rel_valid", 32'(valid), 32'h19);
    check("rel_fcnt", flush_cnt, 32'h4);
    check("rel_scnt", stall_cnt, 32'h6);

    // Reset asserted during an MC wait.
    tick();
    id_is_mc = 1'b1;
    tick();
    id_is_mc = 1'b0;
    #1 check("mrst_pre_mh", 32'(mc_hazard), 32'h1);
    tick();
    reset = 1'b0;
    #1;
    check("mrst_valid", 32'(valid), 32'h0);
    check("mrst_stall", 32'(stall), 32'h0);
    check("mrst_flush", 32'(flush), 32'h0);
    check("mrst_mh", 32'(mc_hazard), 32'h0);
    check("mrst_lh", 32'(load_hazard), 32'h0);
    check("mrst_scnt", stall_cnt, 32'h0);
    check("mrst_fcnt", flush_cnt, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
